// File: rtl/theta_gen.sv
`default_nettype none
// ============================================================================
// Module      : theta_gen
// Description : Multi-channel modular phase generator. A prescaler advances a
//               base phase once every DIV enabled cycles; NCH channels output
//               the base phase plus evenly spaced offsets, modulo MOD. After
//               burst_len full periods the generator pauses for PAUSE enabled
//               cycles with the phase parked at zero (burst_len=0: never).
// Revision    : 1.0 - initial release
// ============================================================================
module theta_gen #(
  parameter int WIDTH = 7,
  parameter int MOD   = 89,
  parameter int DIV   = 5681,
  parameter int PAUSE = 500000,
  parameter int NCH   = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [7:0]           burst_len,
  output logic [NCH*WIDTH-1:0] theta,
  output logic                 tick,
  output logic                 wrap,
  output logic                 pausing
);

  localparam int OFF = MOD / NCH;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CW  = (PAUSE > 1) ? $clog2(PAUSE) : 1;

  localparam logic [0:0] S_RUN   = 1'b0;
  localparam logic [0:0] S_PAUSE = 1'b1;

  localparam logic [PW-1:0]    C_DIV_LAST   = PW'(DIV - 1);
  localparam logic [CW-1:0]    C_PAUSE_LAST = CW'(PAUSE - 1);
  localparam logic [WIDTH-1:0] C_P_LAST     = WIDTH'(MOD - 1);
  localparam logic [WIDTH:0]   C_MOD        = (WIDTH + 1)'(MOD);

  logic [0:0]           state_q, state_d;
  logic [PW-1:0]        presc_q, presc_d;
  logic [WIDTH-1:0]     p_q, p_d;
  logic [7:0]           burst_q, burst_d;
  logic [CW-1:0]        pcnt_q, pcnt_d;
  logic                 tick_q, tick_d;
  logic                 wrap_q, wrap_d;
  logic [NCH*WIDTH-1:0] theta_q, theta_d;
  logic [NCH*WIDTH-1:0] w_theta_rst;

  logic                 w_step;
  logic                 w_p_wrap;
  logic [8:0]           w_burst_inc;
  logic                 w_burst_end;
  logic                 w_pause_end;

  // Event decode: step, period wrap, end of burst and end of pause.
  // The burst comparison uses >= so that lowering burst_len below the
  // count already reached still ends the burst at the next wrap.
  assign w_step      = (state_q == S_RUN) && en && (presc_q == C_DIV_LAST);
  assign w_p_wrap    = w_step && (p_q == C_P_LAST);
  assign w_burst_inc = {1'b0, burst_q} + 9'd1;
  assign w_burst_end = w_p_wrap && (burst_len != 8'd0) &&
                       (w_burst_inc >= {1'b0, burst_len});
  assign w_pause_end = (state_q == S_PAUSE) && en && (pcnt_q == C_PAUSE_LAST);

  // Channel phases computed from the next base phase so they update with p.
  // k*OFF < MOD, so one conditional subtract completes the modulo.
  for (genvar k = 0; k < NCH; k++) begin : g_ch
    localparam logic [WIDTH:0] C_K_OFF = (WIDTH + 1)'(k * OFF);
    logic [WIDTH:0] w_sum;
    assign w_sum = {1'b0, p_d} + C_K_OFF;
    assign theta_d[k*WIDTH +: WIDTH] = (w_sum >= C_MOD) ? WIDTH'(w_sum - C_MOD)
                                                         : w_sum[WIDTH-1:0];
    assign w_theta_rst[k*WIDTH +: WIDTH] = C_K_OFF[WIDTH-1:0];
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN:   if (w_burst_end) state_d = S_PAUSE;
      S_PAUSE: if (w_pause_end) state_d = S_RUN;
      default: state_d = S_RUN;
    endcase
  end

  // Datapath next values: prescaler, phase, burst/pause counters, pulses.
  always_comb begin
    presc_d = presc_q;
    p_d     = p_q;
    burst_d = burst_q;
    pcnt_d  = pcnt_q;
    tick_d  = 1'b0;
    wrap_d  = 1'b0;
    if (en) begin
      case (state_q)
        S_RUN: begin
          if (w_step) begin
            presc_d = '0;
            p_d     = w_p_wrap ? '0 : p_q + WIDTH'(1);
            tick_d  = 1'b1;
            wrap_d  = w_p_wrap;
            if (w_p_wrap) begin
              burst_d = w_burst_end ? 8'd0 : w_burst_inc[7:0];
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        S_PAUSE: begin
          p_d     = '0;
          presc_d = '0;
          pcnt_d  = w_pause_end ? '0 : pcnt_q + CW'(1);
        end
        default: begin
          p_d = '0;
        end
      endcase
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      p_q     <= '0;
      burst_q <= '0;
      pcnt_q  <= '0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
      theta_q <= w_theta_rst;
    end else begin
      presc_q <= presc_d;
      p_q     <= p_d;
      burst_q <= burst_d;
      pcnt_q  <= pcnt_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
      theta_q <= theta_d;
    end
  end

  // Output decode.
  always_comb begin
    theta   = theta_q;
    tick    = tick_q;
    wrap    = wrap_q;
    pausing = (state_q == S_PAUSE);
  end

endmodule
`default_nettype wire

// File: tb/tb_theta_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_theta_gen
// Description : Self-checking bench for theta_gen (MOD=5, DIV=3, NCH=3,
//               PAUSE=4). Table vectors, directed corner sequences and random
//               stimulus compared against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_theta_gen;

  localparam int WIDTH = 7;
  localparam int MOD   = 5;
  localparam int DIV   = 3;
  localparam int PAUSE = 4;
  localparam int NCH   = 3;
  localparam int OFF   = MOD / NCH;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 en;
  logic [7:0]           burst_len;
  logic [NCH*WIDTH-1:0] theta;
  logic                 tick;
  logic                 wrap;
  logic                 pausing;

  theta_gen #(
    .WIDTH(WIDTH), .MOD(MOD), .DIV(DIV), .PAUSE(PAUSE), .NCH(NCH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .burst_len(burst_len),
    .theta    (theta),
    .tick     (tick),
    .wrap     (wrap),
    .pausing  (pausing)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Behavioural model: enabled run cycles since last step, phase, completed
  // periods this burst, pause cycles remaining.
  int m_ph = 0, m_rc = 0, m_bc = 0, m_left = 0;
  bit m_paused = 0, m_tick = 0, m_wrap = 0;

  typedef struct {
    bit r;
    bit e;
    int bl;
    int ch0;
    int ch2;
    bit t;
    bit w;
  } vec_t;
  vec_t tbl[16];

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic int chan(input int k);
    return int'(theta[k*WIDTH +: WIDTH]);
  endfunction

  task automatic model_step(input bit r, input bit e, input int bl);
    m_tick = 0;
    m_wrap = 0;
    if (r) begin
      m_ph = 0; m_rc = 0; m_bc = 0; m_left = 0; m_paused = 0;
    end else if (e) begin
      if (!m_paused) begin
        m_rc++;
        if (m_rc == DIV) begin
          m_rc   = 0;
          m_ph   = (m_ph + 1) % MOD;
          m_tick = 1;
          m_wrap = (m_ph == 0);
          if (m_wrap) begin
            m_bc++;
            if (bl != 0 && m_bc >= bl) begin
              m_bc = 0; m_paused = 1; m_left = PAUSE;
            end
          end
        end
      end else begin
        m_left--;
        if (m_left == 0) begin
          m_paused = 0; m_rc = 0;
        end
      end
    end
  endtask

  // One clock: drive, advance model, compare every output against it.
  task automatic cyc(input bit r, input bit e, input int bl);
    rst = r; en = e; burst_len = bl[7:0];
    @(posedge clk);
    model_step(r, e, bl);
    #1;
    for (int k = 0; k < NCH; k++) check($sformatf("theta[%0d]", k), chan(k), (m_ph + k*OFF) % MOD);
    check("tick", int'(tick), int'(m_tick));
    check("wrap", int'(wrap), int'(m_wrap));
    check("pausing", int'(pausing), int'(m_paused));
  endtask

  initial begin
    int n;
    bit done;
    int snap0, snap1, snap2;
    int bl_r;

    rst = 1'b1; en = 1'b0; burst_len = 8'd0;

    // Table: reset then continuous running, one full period of channel 0.
    for (int i = 0; i < 16; i++) begin
      tbl[i].r   = (i == 0);
      tbl[i].e   = 1'b1;
      tbl[i].bl  = 0;
      tbl[i].t   = (i != 0) && (i % 3 == 0);
      tbl[i].w   = (i == 15);
      tbl[i].ch0 = (i / 3) % 5;
      tbl[i].ch2 = ((i / 3) + 2) % 5;
    end
    for (int i = 0; i < 16; i++) begin
      rst = tbl[i].r; en = tbl[i].e; burst_len = tbl[i].bl[7:0];
      @(posedge clk);
      model_step(tbl[i].r, tbl[i].e, tbl[i].bl);
      #1;
      check($sformatf("tbl%0d ch0", i), chan(0), tbl[i].ch0);
      check($sformatf("tbl%0d ch1", i), chan(1), (tbl[i].ch0 + 1) % 5);
      check($sformatf("tbl%0d ch2", i), chan(2), tbl[i].ch2);
      check($sformatf("tbl%0d tick", i), int'(tick), int'(tbl[i].t));
      check($sformatf("tbl%0d wrap", i), int'(wrap), int'(tbl[i].w));
      check($sformatf("tbl%0d pausing", i), int'(pausing), 0);
    end

    // Burst of 2 periods: pause length, parked theta, restart latency.
    cyc(1, 1, 2);
    done = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      cyc(0, 1, 2);
      if (pausing) done = 1;
    end
    check("burst reaches pause", int'(done), 1);
    n = 0;
    while (pausing && n < 20) begin
      n++;
      check("pause ch0", chan(0), 0);
      check("pause ch1", chan(1), 1);
      check("pause ch2", chan(2), 2);
      cyc(0, 1, 2);
    end
    check("pause length", n, 4);
    n = 0;
    done = 0;
    for (int i = 0; i < 10 && !done; i++) begin
      cyc(0, 1, 2);
      n++;
      if (tick) done = 1;
    end
    check("tick after pause", n, 3);

    // en pulsed low for 5 cycles: frozen outputs, spacing over enabled cycles.
    cyc(1, 1, 0);
    for (int i = 0; i < 7; i++) cyc(0, 1, 0);
    snap0 = chan(0); snap1 = chan(1); snap2 = chan(2);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0);
      check("frozen ch0", chan(0), snap0);
      check("frozen ch2", chan(2), snap2);
      check("frozen tick", int'(tick), 0);
    end
    n = 1;
    done = 0;
    for (int i = 0; i < 10 && !done; i++) begin
      cyc(0, 1, 0);
      n++;
      if (tick) done = 1;
    end
    check("tick spacing across en gap", n, 3);
    check("step after gap ch1", chan(1), (snap1 + 1) % 5);

    // Reset during PAUSE: progress discarded, first tick DIV cycles later.
    cyc(1, 1, 1);
    done = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      cyc(0, 1, 1);
      if (pausing) done = 1;
    end
    check("single burst reaches pause", int'(done), 1);
    cyc(0, 1, 1);
    cyc(1, 1, 1);
    check("rst in pause pausing", int'(pausing), 0);
    check("rst in pause ch0", chan(0), 0);
    check("rst in pause ch2", chan(2), 2);
    n = 0;
    done = 0;
    for (int i = 0; i < 10 && !done; i++) begin
      cyc(0, 1, 1);
      n++;
      if (tick) done = 1;
    end
    check("tick after rst", n, 3);

    // Random traffic with occasional resets and burst_len changes.
    cyc(1, 1, 0);
    bl_r = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) bl_r = $urandom_range(0, 3);
      cyc($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, bl_r);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/theta_gen.md
THETA_GEN -- requirements
Module: theta_gen

Interface
REQ-001: Parameter WIDTH, default 7, bit width of each phase output.
REQ-002: Parameter MOD, default 89, phase modulus; SHALL satisfy 2 <= MOD <= 2**WIDTH.
REQ-003: Parameter DIV, default 5681, clk cycles per phase step; SHALL be >= 1.
REQ-004: Parameter PAUSE, default 500000, clk cycles spent in PAUSE after a completed burst; SHALL be >= 1.
REQ-005: Parameter NCH, default 3, number of phase channels; SHALL satisfy 1 <= NCH <= MOD.
REQ-006: clk  input  1  single clock; all state updates on its rising edge.
REQ-007: rst  input  1  synchronous, active-high reset.
REQ-008: en  input  1  run enable; low freezes all state.
REQ-009: burst_len  input  8  full phase periods per burst; 0 = continuous, never pause.
REQ-010: theta  output  NCH*WIDTH  registered channel phases; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-011: tick  output  1  registered one-cycle pulse on each phase step.
REQ-012: wrap  output  1  registered one-cycle pulse when channel 0 steps from MOD-1 to 0.
REQ-013: pausing  output  1  high while the FSM is in PAUSE.

Function
REQ-014: Internal base phase p SHALL be a WIDTH-bit value in 0..MOD-1; the channel offset SHALL be OFF = floor(MOD/NCH).
REQ-015: Channel k output SHALL equal (p + k*OFF) mod MOD; the sum SHALL be computed wide enough that it never overflows; every channel SHALL update in the same cycle as p.
REQ-016: The FSM SHALL have two states: RUN and PAUSE.
REQ-017: In RUN with en=1, a prescaler SHALL count 0..DIV-1 and then wrap to 0; the cycle in which it holds DIV-1 SHALL be a step cycle.
REQ-018: On a step cycle, p SHALL update to (p+1) mod MOD, and tick SHALL be 1 in the following cycle, coincident with the new theta.
REQ-019: DIV=1 SHALL give a step on every enabled RUN cycle.
REQ-020: wrap SHALL assert in the same cycle as tick whenever p changed from MOD-1 to 0.
REQ-021: A burst counter SHALL increment on each wrap event.
REQ-022: With burst_len != 0, the wrap event that brings the burst counter to burst_len SHALL, in that same update, clear the burst counter, clear the prescaler and transition to PAUSE.
REQ-023: In PAUSE, p SHALL be held at 0, so channel k outputs k*OFF; tick and wrap SHALL be 0.
REQ-024: In PAUSE, a pause counter SHALL count enabled cycles; after PAUSE enabled cycles the FSM SHALL return to RUN with the prescaler at 0.
REQ-025: With burst_len=0 the FSM SHALL never enter PAUSE.
REQ-026: burst_len SHALL be sampled on every wrap event; changing it mid-burst SHALL take effect at the next wrap event.
REQ-027: If burst_len is lowered below the current burst count, the next wrap event SHALL end the burst.
REQ-028: With en=0, the prescaler, p, the burst counter, the pause counter and the FSM state SHALL all hold; tick and wrap SHALL be 0; theta and pausing SHALL hold.
REQ-029: When en returns to 1, counting SHALL resume from the held values with no lost or extra steps.

Reset
REQ-030: When rst=1 at a clk edge, the following SHALL take effect on that edge, overriding en: state=RUN; p=0; all counters=0; tick=0; wrap=0; pausing=0; channel k = k*OFF.
REQ-031: Reset asserted mid-burst or mid-pause SHALL discard all progress; the first step after release SHALL occur DIV enabled cycles later.

Verification
REQ-032: Bench configuration for REQ-033 to REQ-036 SHALL be MOD=5, DIV=3, NCH=3 (OFF=1), PAUSE=4, WIDTH=7.
REQ-033: Reset, then en=1 and burst_len=0 -> tick every 3rd cycle; channel 0 sequence 0,1,2,3,4,0; channel 2 sequence 2,3,4,0,1; wrap coincides with channel 0 returning to 0; pausing stays 0.
REQ-034: burst_len=2 -> after the 2nd wrap, pausing=1 for exactly 4 cycles with theta={2,1,0}; the first tick occurs 3 cycles after pausing deasserts.
REQ-035: en pulsed low for 5 cycles mid-run -> theta frozen throughout; tick spacing measured over enabled cycles stays exactly 3.
REQ-036: rst asserted for 1 cycle during PAUSE -> pausing=0 and theta={2,1,0} after the edge; first tick 3 cycles later.
REQ-037: Default parameters, burst_len=1 -> channel 0 wraps after 89*5681 cycles; channel 1 starts at 29; PAUSE lasts 500000 cycles.
